letc_core_limp_arbiter: RTL and testbench

LETC_CORE_LIMP_ARBITER -- requirements
Module: letc_core_limp_arbiter

---
 rtl/letc_core_limp_arbiter.sv | 150 +++++++++++++++
 tb/tb_letc_core_limp_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/letc_core_limp_arbiter.sv
// Arbitrates NUM_REQ LIMP requestors onto one downstream LIMP port (round-robin by default).
// Define LETC_CORE_LIMP_ARB_FIXED_PRIO_EN for fixed priority, index 0 highest, with no pointer.
module letc_core_limp_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SIZE_W  = 2,
  parameter int unsigned PADDR_W = 32,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                            i_clk,
  input  logic                            i_rst,

  input  logic [NUM_REQ-1:0]              i_req_valid,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [NUM_REQ-1:0]              i_req_wen_nren,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0]  i_req_size,
  input  logic [NUM_REQ-1:0][PADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0][WORD_W-1:0]  i_req_wdata,
  output logic [WORD_W-1:0]               o_req_rdata,

  output logic                            o_valid,
  output logic                            o_wen_nren,
  output logic [SIZE_W-1:0]               o_size,
  output logic [PADDR_W-1:0]              o_addr,
  output logic [WORD_W-1:0]               o_wdata,
  input  logic                            i_ready,
  input  logic [WORD_W-1:0]               i_rdata
);

  localparam int unsigned GntW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state_q;
  logic [GntW-1:0] gnt_q;
  logic [GntW-1:0] gnt_sel;
  logic [GntW-1:0] sel_lo;

`ifdef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN

  always_comb begin
    sel_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) sel_lo = GntW'(i);
    end
  end

  assign gnt_sel = sel_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|i_req_valid) begin
            gnt_q   <= gnt_sel;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (i_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`else

  logic [GntW-1:0] ptr_q;
  logic [GntW-1:0] sel_hi;
  logic            found_hi;

  // sel_hi: first valid at or above ptr_q; sel_lo: first valid overall (the wrapped search).
  always_comb begin
    sel_lo   = '0;
    sel_hi   = '0;
    found_hi = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        sel_lo = GntW'(i);
        if (GntW'(i) >= ptr_q) begin
          sel_hi   = GntW'(i);
          found_hi = 1'b1;
        end
      end
    end
  end

  assign gnt_sel = found_hi ? sel_hi : sel_lo;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (|i_req_valid) begin
            gnt_q   <= gnt_sel;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (i_ready) begin
            state_q <= StIdle;
            // The winner drops to lowest priority for the next arbitration.
            ptr_q   <= (gnt_q == GntW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`endif

  assign o_valid     = (state_q == StBusy);
  assign o_wen_nren  = i_req_wen_nren[gnt_q];
  assign o_size      = i_req_size[gnt_q];
  assign o_addr      = i_req_addr[gnt_q];
  assign o_wdata     = i_req_wdata[gnt_q];
  assign o_req_rdata = i_rdata;

  always_comb begin
    o_req_ready = '0;
    if (state_q == StBusy) o_req_ready[gnt_q] = i_ready;
  end

`ifdef SIMULATION
  a_ready_onehot0 : assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0(o_req_ready))
    else $error("o_req_ready not onehot0");

  a_idle_no_valid : assert property (@(posedge i_clk) disable iff (i_rst)
      (state_q == StIdle) |-> !o_valid)
    else $error("o_valid asserted in IDLE");

  a_fields_stable : assert property (@(posedge i_clk) disable iff (i_rst)
      (o_valid && !i_ready) |=> $stable({o_wen_nren, o_size, o_addr, o_wdata}))
    else $error("downstream fields changed while stalled");

  a_no_valid_drop : assert property (@(posedge i_clk) disable iff (i_rst)
      (state_q == StBusy) |-> i_req_valid[gnt_q])
    else $error("granted requestor dropped valid before ready");
`endif

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Scoreboard bench for letc_core_limp_arbiter: a 2-requestor and a 4-requestor instance.
module tb_letc_core_limp_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // NUM_REQ = 2 instance
  logic [1:0]        valid2, ready2, wen2;
  logic [1:0][1:0]   size2;
  logic [1:0][31:0]  addr2, wdata2;
  logic [31:0]       rdata2, irdata2, oaddr2, owdata2;
  logic              ovalid2, owen2, iready2;
  logic [1:0]        osize2;

  // NUM_REQ = 4 instance
  logic [3:0]        valid4, ready4, wen4;
  logic [3:0][1:0]   size4;
  logic [3:0][31:0]  addr4, wdata4;
  logic [31:0]       rdata4, irdata4, oaddr4, owdata4;
  logic              ovalid4, owen4, iready4;
  logic [1:0]        osize4;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_ptr2, m_ptr4;

  letc_core_limp_arbiter #(.NUM_REQ(2)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid2), .o_req_ready(ready2), .i_req_wen_nren(wen2),
    .i_req_size(size2), .i_req_addr(addr2), .i_req_wdata(wdata2), .o_req_rdata(rdata2),
    .o_valid(ovalid2), .o_wen_nren(owen2), .o_size(osize2), .o_addr(oaddr2),
    .o_wdata(owdata2), .i_ready(iready2), .i_rdata(irdata2)
  );

  letc_core_limp_arbiter #(.NUM_REQ(4)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(valid4), .o_req_ready(ready4), .i_req_wen_nren(wen4),
    .i_req_size(size4), .i_req_addr(addr4), .i_req_wdata(wdata4), .o_req_rdata(rdata4),
    .o_valid(ovalid4), .o_wen_nren(owen4), .o_size(osize4), .o_addr(oaddr4),
    .o_wdata(owdata4), .i_ready(iready4), .i_rdata(irdata4)
  );

  // Reference arbitration decision.
  function automatic int model_gnt(input logic [3:0] v, input int ptr, input int n);
`ifdef LETC_CORE_LIMP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < n; i++) if (v[i]) return i;
    if (ptr < 0) return -1;
`else
    for (int k = 0; k < n; k++) if (v[(ptr + k) % n]) return (ptr + k) % n;
`endif
    return -1;
  endfunction

  task automatic push_seq2(input logic [1:0] v, input int cnt);
    int g;
    for (int k = 0; k < cnt; k++) begin
      g = model_gnt({2'b00, v}, m_ptr2, 2);
      exp_q.push_back(g);
      m_ptr2 = (g + 1) % 2;
    end
  endtask

  task automatic push_seq4(input logic [3:0] v, input int cnt);
    int g;
    for (int k = 0; k < cnt; k++) begin
      g = model_gnt(v, m_ptr4, 4);
      exp_q.push_back(g);
      m_ptr4 = (g + 1) % 4;
    end
  endtask

  // One transaction on dut2: wait for o_valid, stall `delay` cycles, then complete with rd.
  task automatic handshake2(input int delay, input bit b2b, input bit toggle0,
                            input logic [31:0] rd);
    int e;
    int c;
    logic [1:0] exp_r;
    c = 0;
    do begin @(negedge clk); c++; end while (ovalid2 !== 1'b1 && c < 20);
    checks++;
    if (ovalid2 !== 1'b1) begin
      errors++;
      $display("FAIL valid2_wait: o_valid=%b after %0d cycles, required 1", ovalid2, c);
      return;
    end
    if (b2b) begin
      checks++;
      if (c != 1) begin
        errors++;
        $display("FAIL latency2: o_valid after %0d cycles, required 1", c);
      end
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb2_empty: unexpected transaction addr=%h, required none", oaddr2);
      return;
    end
    e = exp_q.pop_front();
    exp_r = '0;
    exp_r[e] = 1'b1;
    for (int i = 0; i < delay; i++) begin
      iready2 = 1'b0;
      #1;
      checks++;
      if (ready2 !== 2'b00 || ovalid2 !== 1'b1 ||
          {owen2, osize2, oaddr2, owdata2} !== {wen2[e], size2[e], addr2[e], wdata2[e]}) begin
        errors++;
        $display("FAIL stall2: ready=%b valid=%b addr=%h, required ready=00 valid=1 addr=%h",
                 ready2, ovalid2, oaddr2, addr2[e]);
      end
      @(negedge clk);
      if (toggle0) valid2[0] = ~valid2[0];
    end
    iready2 = 1'b1;
    irdata2 = rd;
    #1;
    checks++;
    if ({owen2, osize2, oaddr2, owdata2} !== {wen2[e], size2[e], addr2[e], wdata2[e]}) begin
      errors++;
      $display("FAIL fields2: wen=%b size=%b addr=%h wdata=%h, required %b %b %h %h",
               owen2, osize2, oaddr2, owdata2, wen2[e], size2[e], addr2[e], wdata2[e]);
    end
    checks++;
    if (ready2 !== exp_r || rdata2 !== rd) begin
      errors++;
      $display("FAIL ready2: ready=%b rdata=%h, required ready=%b rdata=%h",
               ready2, rdata2, exp_r, rd);
    end
    @(negedge clk);
    iready2 = 1'b0;
    #1;
    checks++;
    if (ovalid2 !== 1'b0 || ready2 !== 2'b00) begin
      errors++;
      $display("FAIL gap2: valid=%b ready=%b, required valid=0 ready=00", ovalid2, ready2);
    end
  endtask

  task automatic handshake4(input bit b2b, input logic [31:0] rd);
    int e;
    int c;
    logic [3:0] exp_r;
    c = 0;
    do begin @(negedge clk); c++; end while (ovalid4 !== 1'b1 && c < 20);
    checks++;
    if (ovalid4 !== 1'b1 || (b2b && c != 1)) begin
      errors++;
      $display("FAIL valid4_wait: o_valid=%b after %0d cycles, required 1 after 1",
               ovalid4, c);
      return;
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb4_empty: unexpected transaction addr=%h, required none", oaddr4);
      return;
    end
    e = exp_q.pop_front();
    exp_r = '0;
    exp_r[e] = 1'b1;
    iready4 = 1'b1;
    irdata4 = rd;
    #1;
    checks++;
    if (oaddr4 !== addr4[e] || owdata4 !== wdata4[e] || ready4 !== exp_r || rdata4 !== rd) begin
      errors++;
      $display("FAIL grant4: addr=%h ready=%b rdata=%h, required addr=%h ready=%b rdata=%h",
               oaddr4, ready4, rdata4, addr4[e], exp_r, rd);
    end
    @(negedge clk);
    iready4 = 1'b0;
    #1;
    checks++;
    if (ovalid4 !== 1'b0 || ready4 !== 4'b0000) begin
      errors++;
      $display("FAIL gap4: valid=%b ready=%b, required valid=0 ready=0000", ovalid4, ready4);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    valid2 = '0; valid4 = '0;
    iready2 = 1'b0; iready4 = 1'b0;
    irdata2 = 32'h1234_5678; irdata4 = 32'hCAFE_0004;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ovalid2 !== 1'b0 || ready2 !== 2'b00 || rdata2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset2: valid=%b ready=%b rdata=%h, required 0 00 12345678",
               ovalid2, ready2, rdata2);
    end
    checks++;
    if (ovalid4 !== 1'b0 || ready4 !== 4'b0000 || rdata4 !== 32'hCAFE_0004) begin
      errors++;
      $display("FAIL reset4: valid=%b ready=%b rdata=%h, required 0 0000 cafe0004",
               ovalid4, ready4, rdata4);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (ovalid2 !== 1'b0 || ready2 !== 2'b00 || ovalid4 !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: valid2=%b ready2=%b valid4=%b, required 0 00 0",
               ovalid2, ready2, ovalid4);
    end
    m_ptr2 = 0;
    m_ptr4 = 0;
    exp_q.delete();
  endtask

  task automatic test_single_read;
    wen2[0]  = 1'b0;
    addr2[0] = 32'h0000_1000;
    valid2   = 2'b01;
    push_seq2(2'b01, 1);
    handshake2(3, 1'b1, 1'b0, 32'hDEAD_BEEF);
    valid2 = 2'b00;
  endtask

  task automatic test_back_to_back;
    test_reset();
    valid2 = 2'b11;
    push_seq2(2'b11, 4);
    for (int k = 0; k < 4; k++) handshake2(0, 1'b1, 1'b0, 32'hB000_0000 + k);
    valid2 = 2'b00;
  endtask

  task automatic test_no_preempt;
    valid2 = 2'b10;
    push_seq2(2'b10, 1);
    handshake2(10, 1'b1, 1'b1, 32'h5A5A_0001);
    valid2 = 2'b00;
  endtask

  task automatic test_reset_busy;
    int c;
    valid2 = 2'b10;
    c = 0;
    do begin @(negedge clk); c++; end while (ovalid2 !== 1'b1 && c < 20);
    checks++;
    if (ovalid2 !== 1'b1 || oaddr2 !== addr2[1]) begin
      errors++;
      $display("FAIL busy_req1: valid=%b addr=%h, required 1 %h", ovalid2, oaddr2, addr2[1]);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ovalid2 !== 1'b0 || ready2 !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy: valid=%b ready=%b, required 0 00", ovalid2, ready2);
    end
    rst = 1'b0;
    m_ptr2 = 0;
    valid2 = 2'b11;
    push_seq2(2'b11, 2);
    handshake2(0, 1'b1, 1'b0, 32'h0F0F_0F0F);
    handshake2(0, 1'b1, 1'b0, 32'hF0F0_F0F0);
    valid2 = 2'b00;
  endtask

  task automatic test_rr_wrap4;
    valid4 = 4'hF;
    push_seq4(4'hF, 6);
    for (int k = 0; k < 6; k++) handshake4(1'b1, $urandom);
    valid4 = 4'b1010;
    push_seq4(4'b1010, 3);
    for (int k = 0; k < 3; k++) handshake4(1'b1, $urandom);
    valid4 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      wen2[i]   = 1'(i);
      size2[i]  = 2'(i + 1);
      addr2[i]  = 32'h1000 + 32'(i) * 32'h100;
      wdata2[i] = 32'hA000_0000 + 32'(i);
    end
    for (int i = 0; i < 4; i++) begin
      wen4[i]   = 1'(i);
      size4[i]  = 2'(i);
      addr4[i]  = 32'h2000 + 32'(i) * 32'h40;
      wdata4[i] = 32'hC000_0000 + 32'(i);
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_no_preempt();
    test_reset_busy();
    test_rr_wrap4();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected transactions unseen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
